cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among N_REQ functional units: ALUs, branch unit, load unit.
- Each requester gets a one-entry holding buffer, so a unit can retire a result without stalling.
- Buffered results are granted round-robin, one per cycle, and driven onto a registered CDB.
- The registered CDB is read by reservation stations, the register file and the ROB.

---
 rtl/tomasula_types.sv | 25 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasula_types.sv
// ============================================================================
//  Module      : tomasula_types (package)
//  Description : Shared types for the Tomasulo back end. cdb_data is the
//                packet broadcast on the common data bus: {tag, data}.
//                CDB_W is its width. cdb_vec_t is a fixed-size array of
//                packets, sized by the default requester count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tomasula_types;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } cdb_data;

    localparam int CDB_W      = $bits(cdb_data);
    localparam int N_REQ_DFLT = 4;

    typedef cdb_data cdb_vec_t [N_REQ_DFLT];

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Scans the request
//                vector starting at i_ptr and wrapping modulo N_REQ. It
//                grants the first set bit it finds.
//  Ports       : i_req  - request vector
//                i_ptr  - highest-priority index for this cycle
//                o_gnt  - one-hot grant, all zeros when there is no request
//                o_idx  - encoded grant index, 0 when there is no request
//                o_any  - at least one grant issued
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;
    logic             w_hit;

    // Walk the candidates in priority order. The sum is one bit wider than
    // the pointer so that the modulo wrap works for any N_REQ. A single
    // subtract is enough because i_ptr < N_REQ and k < N_REQ.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_hit  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(N_REQ);
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_hit && i_req[w_cand]) begin
                w_hit         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

    assign o_any = w_hit;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares the common data bus among N_REQ functional units.
//                Each requester has a one-entry holding buffer. Full buffers
//                are granted round-robin, one per cycle, onto a registered
//                CDB.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                flush            - drops all buffered and in-flight results
//                req_valid/ready  - per-requester accept handshake
//                req_data         - per-requester cdb_data packet
//                cdb_valid        - registered broadcast valid
//                cdb_out          - registered broadcast packet
//                grant_idx        - source index of cdb_out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N_REQ-1:0]     req_valid,
    input  cdb_data [N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 cdb_valid,
    output cdb_data              cdb_out,
    output logic [PTR_W-1:0]     grant_idx
);

    logic [N_REQ-1:0]    r_buf_valid;
    cdb_data [N_REQ-1:0] r_buf_data;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic                r_cdb_valid;
    cdb_data             r_cdb_out;
    logic [PTR_W-1:0]    r_grant_idx;

    logic [N_REQ-1:0]    w_gnt;
    logic [N_REQ-1:0]    w_accept;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                w_any;
    logic                w_open;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req (r_buf_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    // A buffer that drains this cycle can take a new packet in the same
    // cycle. This gives one result per requester per cycle when there is no
    // contention.
    assign w_open    = !rst && !flush;
    assign req_ready = {N_REQ{w_open}} & (~r_buf_valid | w_gnt);
    assign w_accept  = req_valid & req_ready;

    // After a grant, priority moves to the requester after the winner.
    assign w_ptr_next = (w_gnt_idx == PTR_W'(N_REQ-1)) ? '0
                                                       : w_gnt_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
            r_buf_data  <= '0;
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_out   <= '0;
            r_grant_idx <= '0;
        end else if (flush) begin
            // The pointer is kept so fairness carries across a mispredict.
            // cdb_out and grant_idx keep their values; without cdb_valid
            // they carry no meaning.
            r_buf_valid <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            r_buf_valid <= (r_buf_valid & ~w_gnt) | w_accept;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_buf_data[i] <= req_data[i];
                end
            end
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_out   <= r_buf_data[w_gnt_idx];
                r_grant_idx <= w_gnt_idx;
                r_rr_ptr    <= w_ptr_next;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_out   = r_cdb_out;
    assign grant_idx = r_grant_idx;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. It runs directed
//                scenarios followed by random traffic. Results are compared
//                against a cycle-level reference model of buffer occupancy
//                and round-robin priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import tomasula_types::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    cdb_data [N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    cdb_data         cdb_out;
    logic [1:0]      grant_idx;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_out   (cdb_out),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit      m_full [N];
    cdb_data m_pkt  [N];
    int      m_ptr;
    bit      m_cv;
    cdb_data m_out;
    int      m_gi;
    bit [N-1:0] last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_full[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        g = m_pick();
        for (int i = 0; i < N; i++)
            r[i] = !rst && !flush && (!m_full[i] || g == i);
        return r;
    endfunction

    task automatic check_all();
        #1;
        chk("req_ready", 64'(req_ready), 64'(m_ready()));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
        chk("cdb_out",   64'(cdb_out),   64'(m_out));
        chk("grant_idx", 64'(grant_idx), 64'(m_gi));
    endtask

    // Advance one clock edge and update the model with the inputs held there.
    task automatic step();
        logic [N-1:0] rdy;
        int g;
        rdy = m_ready();
        g   = m_pick();
        @(posedge clk);
        last_acc = req_valid & rdy;
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_ptr = 0; m_cv = 0; m_out = '0; m_gi = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_cv = 0;
        end else begin
            if (g >= 0) begin
                m_cv = 1; m_out = m_pkt[g]; m_gi = g;
                m_ptr = (g + 1) % N; m_full[g] = 0;
            end else begin
                m_cv = 0;
            end
            for (int i = 0; i < N; i++)
                if (last_acc[i]) begin
                    m_full[i] = 1; m_pkt[i] = req_data[i];
                end
        end
        @(negedge clk);
    endtask

    function automatic cdb_data rand_pkt();
        cdb_data p;
        p.tag  = 3'($urandom);
        p.data = $urandom;
        return p;
    endfunction

    // Random requesters respect the protocol: a pending request is held
    // until it has been accepted.
    task automatic drive_rand(input int pv);
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !last_acc[i])) begin
                req_valid[i] = ($urandom_range(99) < pv);
                req_data[i]  = rand_pkt();
            end
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            check_all();
            step();
        end
    endtask

    initial begin
        int g_before;
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0;
        last_acc = '0;
        @(negedge clk);
        step();
        check_all();
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_out",   64'(cdb_out),   64'd0);
        chk("rst_ready",     64'(req_ready), 64'd0);
        step();
        rst = 1'b0;

        // Full contention: tags 0..3 from pointer 0, refills held pending.
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1;
            req_data[i]  = {3'(i), 32'h1000 + 32'(i)};
        end
        check_all();
        step();
        for (int i = 0; i < N; i++) req_data[i] = {3'(i + 4), 32'h2000 + 32'(i)};
        for (int k = 0; k < N; k++) begin
            check_all();
            step();
            for (int i = 0; i < N; i++) if (last_acc[i]) req_valid[i] = 1'b0;
            chk("t2_idx", 64'(grant_idx),   64'(k));
            chk("t2_tag", 64'(cdb_out.tag), 64'(k));
        end
        req_valid = '0;
        drain(6);

        // Single requester 2, one packet.
        req_valid[2] = 1'b1;
        req_data[2]  = {3'd5, 32'hDEAD_BEEF};
        check_all();
        chk("t1_ready", 64'(req_ready[2]), 64'd1);
        step();
        req_valid = '0;
        check_all();
        chk("t1_early", 64'(cdb_valid), 64'd0);
        step();
        chk("t1_valid", 64'(cdb_valid), 64'd1);
        chk("t1_out",   64'(cdb_out),   64'({3'd5, 32'hDEAD_BEEF}));
        chk("t1_idx",   64'(grant_idx), 64'd2);
        check_all();
        step();
        chk("t1_once", 64'(cdb_valid), 64'd0);

        // Fairness and wrap: requesters 0 and 3 always valid, pointer at 3.
        req_valid = 4'b1001;
        req_data[0] = rand_pkt();
        req_data[3] = rand_pkt();
        check_all();
        step();
        for (int k = 0; k < 6; k++) begin
            if (last_acc[0]) req_data[0] = rand_pkt();
            if (last_acc[3]) req_data[3] = rand_pkt();
            check_all();
            step();
            chk("t3_valid", 64'(cdb_valid), 64'd1);
            chk("t3_order", 64'(grant_idx), (k % 2 == 0) ? 64'd3 : 64'd0);
        end
        req_valid = '0;
        drain(4);

        // Streaming: requester 1 sends data 1..8 back-to-back.
        for (int k = 1; k <= 8; k++) begin
            req_valid[1] = 1'b1;
            req_data[1]  = {3'd0, 32'(k)};
            check_all();
            chk("t4_ready", 64'(req_ready[1]), 64'd1);
            step();
            if (k >= 2) chk("t4_data", 64'(cdb_out.data), 64'(k - 1));
        end
        req_valid = '0;
        check_all();
        step();
        chk("t4_last", 64'(cdb_out.data), 64'd8);
        drain(2);

        // Flush with three buffers full and a broadcast on the bus.
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1;
            req_data[i]  = rand_pkt();
        end
        check_all();
        step();
        req_valid = '0;
        check_all();
        step();
        chk("t5_pre_valid", 64'(cdb_valid), 64'd1);
        g_before = m_gi;
        flush = 1'b1;
        req_valid = 4'b1111;
        check_all();
        chk("t5_ready", 64'(req_ready), 64'd0);
        step();
        flush = 1'b0;
        req_valid = '0;
        chk("t5_valid", 64'(cdb_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check_all();
            step();
            chk("t5_stale", 64'(cdb_valid), 64'd0);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i] = rand_pkt();
        check_all();
        step();
        req_valid = '0;
        check_all();
        step();
        chk("t5_ptr", 64'(grant_idx), 64'((g_before + 1) % N));
        drain(5);

        // Reset together with flush, mid traffic.
        for (int k = 0; k < 5; k++) begin
            drive_rand(80);
            check_all();
            step();
        end
        rst = 1'b1; flush = 1'b1;
        check_all();
        chk("t6_ready", 64'(req_ready), 64'd0);
        step();
        chk("t6_valid", 64'(cdb_valid), 64'd0);
        chk("t6_out",   64'(cdb_out),   64'd0);
        chk("t6_idx",   64'(grant_idx), 64'd0);
        rst = 1'b0; flush = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i] = rand_pkt();
        check_all();
        step();
        req_valid = '0;
        check_all();
        step();
        chk("t6_first", 64'(grant_idx), 64'd0);
        chk("t6_first_valid", 64'(cdb_valid), 64'd1);
        drain(4);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++) begin
            rst   = ($urandom_range(99) < 2);
            flush = ($urandom_range(99) < 4);
            drive_rand(50);
            check_all();
            step();
        end
        rst = 1'b0; flush = 1'b0; req_valid = '0;
        drain(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
